// File: rtl/add_sub_pipe_unit.sv
// add_sub_pipe_unit: pipelined integer add/subtract/compare execution unit.
//
// Accepts one op per cycle over input_valid/input_ready, returns it PIPE_STAGES
// cycles later over output_valid/output_ready with the RS tag, destination GPR
// and destination CR field.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   flush                         synchronous; drops every in-flight op
//   input_valid / input_ready     issue handshake
//   rs_id_in, result_reg_addr_in, cr_field_in   tag and destinations
//   op1, op2                      operands (rA, rB)
//   carry_in, so_in               XER[CA], XER[SO]
//   subtract, add_ca, compare, compare_unsigned, alter_ca, alter_ov, alter_cr
//   output_valid / output_ready   result handshake
//   rs_id_out, result_reg_addr_out, cr_field_out  tag and destinations
//   result, ca, ov, cr            sum/difference, XER flags, {LT, GT, EQ, SO}
//   ca_valid, ov_valid, cr_valid  writeback enables
//
// Stage 0 registers the low half of the sum and its carry; stage 1 finishes
// the high half and all flags; later stages only delay the finished result.
module add_sub_pipe_unit #(
  parameter int unsigned RS_ID_WIDTH = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIPE_STAGES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [RS_ID_WIDTH-1:0] rs_id_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic [2:0]             cr_field_in,
  input  logic [DATA_WIDTH-1:0]  op1,
  input  logic [DATA_WIDTH-1:0]  op2,
  input  logic                   carry_in,
  input  logic                   so_in,
  input  logic                   subtract,
  input  logic                   add_ca,
  input  logic                   compare,
  input  logic                   compare_unsigned,
  input  logic                   alter_ca,
  input  logic                   alter_ov,
  input  logic                   alter_cr,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [2:0]             cr_field_out,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   ca,
  output logic                   ov,
  output logic [3:0]             cr,
  output logic                   ca_valid,
  output logic                   ov_valid,
  output logic                   cr_valid
);

  localparam int unsigned N   = PIPE_STAGES;
  localparam int unsigned LO  = DATA_WIDTH / 2;
  localparam int unsigned HI  = DATA_WIDTH - LO;
  localparam int unsigned MSB = DATA_WIDTH - 1;

  // Stage 0 payload: half-finished sum plus everything stage 1 needs.
  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             addr;
    logic [2:0]             crf;
    logic [DATA_WIDTH-1:0]  op1;
    logic [DATA_WIDTH-1:0]  op2;
    logic [LO-1:0]          lo_sum;
    logic                   lo_co;
    logic                   so_in;
    logic                   subtract;
    logic                   compare;
    logic                   compare_unsigned;
    logic                   alter_ca;
    logic                   alter_ov;
    logic                   alter_cr;
  } s0_t;

  // Finished result carried by stages 1..N-1.
  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             addr;
    logic [2:0]             crf;
    logic [DATA_WIDTH-1:0]  result;
    logic                   ca;
    logic                   ov;
    logic [3:0]             cr;
    logic                   ca_valid;
    logic                   ov_valid;
    logic                   cr_valid;
  } res_t;

  logic [N-1:0]          valid_q;
  logic [N-1:0]          en;
  s0_t                   s0_q, s0_d;
  res_t                  res_q [N-1:1];
  res_t                  res_d;

  logic [DATA_WIDTH-1:0] a_in;
  logic                  cin;
  logic [HI-1:0]         a_hi, hi_sum;
  logic                  hi_co;
  logic [DATA_WIDTH-1:0] sum;
  logic                  lt, gt, eq, ovf;

  // Ready ripples back from the output: a stage may load if it is empty or
  // the stage after it is also moving, so bubbles collapse.
  always_comb begin
    logic e;
    e         = output_ready | ~valid_q[N-1];
    en[N-1]   = e;
    for (int k = int'(N) - 2; k >= 0; k--) begin
      e     = ~valid_q[k] | e;
      en[k] = e;
    end
  end

  assign input_ready = en[0] & ~flush;

  // Low half of the carry chain.
  always_comb begin
    s0_d                  = '0;
    a_in                  = subtract ? ~op1 : op1;
    cin                   = add_ca ? carry_in : subtract;
    {s0_d.lo_co, s0_d.lo_sum} = {1'b0, a_in[LO-1:0]} + {1'b0, op2[LO-1:0]}
                              + {{LO{1'b0}}, cin};
    s0_d.rs_id            = rs_id_in;
    s0_d.addr             = result_reg_addr_in;
    s0_d.crf              = cr_field_in;
    s0_d.op1              = op1;
    s0_d.op2              = op2;
    s0_d.so_in            = so_in;
    s0_d.subtract         = subtract;
    s0_d.compare          = compare;
    s0_d.compare_unsigned = compare_unsigned;
    s0_d.alter_ca         = alter_ca;
    s0_d.alter_ov         = alter_ov;
    s0_d.alter_cr         = alter_cr;
  end

  // High half of the carry chain, flags and compare.
  always_comb begin
    res_d          = '0;
    res_d.rs_id    = s0_q.rs_id;
    res_d.addr     = s0_q.addr;
    res_d.crf      = s0_q.crf;
    a_hi           = s0_q.subtract ? ~s0_q.op1[MSB:LO] : s0_q.op1[MSB:LO];
    {hi_co, hi_sum} = {1'b0, a_hi} + {1'b0, s0_q.op2[MSB:LO]} + {{HI{1'b0}}, s0_q.lo_co};
    sum            = {hi_sum, s0_q.lo_sum};
    // Signed overflow: operands agree in sign but the sum does not.
    ovf            = (a_hi[HI-1] == s0_q.op2[MSB]) & (sum[MSB] != a_hi[HI-1]);
    lt             = sum[MSB];
    eq             = (sum == '0);
    gt             = ~lt & ~eq;
    if (s0_q.compare) begin
      lt             = s0_q.compare_unsigned ? (s0_q.op1 < s0_q.op2)
                                             : ($signed(s0_q.op1) < $signed(s0_q.op2));
      eq             = (s0_q.op1 == s0_q.op2);
      gt             = ~lt & ~eq;
      res_d.cr       = {lt, gt, eq, s0_q.so_in};
      res_d.cr_valid = 1'b1;
    end else begin
      res_d.result   = sum;
      res_d.ca       = hi_co;
      res_d.ov       = ovf;
      res_d.cr       = {lt, gt, eq, s0_q.so_in | (s0_q.alter_ov & ovf)};
      res_d.ca_valid = s0_q.alter_ca;
      res_d.ov_valid = s0_q.alter_ov;
      res_d.cr_valid = s0_q.alter_cr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      s0_q    <= '0;
      for (int unsigned k = 1; k < N; k++) res_q[k] <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end else begin
        if (en[0]) valid_q[0] <= input_valid;
        for (int unsigned k = 1; k < N; k++) begin
          if (en[k]) valid_q[k] <= valid_q[k-1];
        end
      end
      if (en[0]) s0_q <= s0_d;
      if (en[1]) res_q[1] <= res_d;
      for (int unsigned k = 2; k < N; k++) begin
        if (en[k]) res_q[k] <= res_q[k-1];
      end
    end
  end

  assign output_valid        = valid_q[N-1];
  assign rs_id_out           = res_q[N-1].rs_id;
  assign result_reg_addr_out = res_q[N-1].addr;
  assign cr_field_out        = res_q[N-1].crf;
  assign result              = res_q[N-1].result;
  assign ca                  = res_q[N-1].ca;
  assign ov                  = res_q[N-1].ov;
  assign cr                  = res_q[N-1].cr;
  assign ca_valid            = res_q[N-1].ca_valid;
  assign ov_valid            = res_q[N-1].ov_valid;
  assign cr_valid            = res_q[N-1].cr_valid;

endmodule

// File: tb/tb_add_sub_pipe_unit.sv
module tb_add_sub_pipe_unit;

  localparam int N  = 4;
  localparam int SN = 2;

  typedef struct packed {
    logic [4:0]  rs_id;
    logic [4:0]  addr;
    logic [2:0]  crf;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        cin, so, sub, add_ca, cmp, cmpu, aca, aov, acr;
  } op_t;

  typedef struct packed {
    logic [4:0]  rs_id;
    logic [4:0]  addr;
    logic [2:0]  crf;
    logic [31:0] result;
    logic        ca, ov;
    logic [3:0]  cr;
    logic        cav, ovv, crv;
  } exp_t;

  typedef struct {
    exp_t e;
    int   acc;
    bit   chk;
    bit   cmp;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int ov_seen    = 0;
  bit chk_lat    = 1'b0;
  sb_t sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT (32 bit, 4 stages)
  op_t  drv;
  logic flush, input_valid, input_ready, output_ready, output_valid;
  logic [4:0] rs_id_out, result_reg_addr_out;
  logic [2:0] cr_field_out;
  logic [31:0] result;
  logic ca, ov, ca_valid, ov_valid, cr_valid;
  logic [3:0] cr;

  add_sub_pipe_unit #(.RS_ID_WIDTH(5), .DATA_WIDTH(32), .PIPE_STAGES(N)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .input_valid(input_valid), .input_ready(input_ready),
    .rs_id_in(drv.rs_id), .result_reg_addr_in(drv.addr), .cr_field_in(drv.crf),
    .op1(drv.op1), .op2(drv.op2), .carry_in(drv.cin), .so_in(drv.so),
    .subtract(drv.sub), .add_ca(drv.add_ca), .compare(drv.cmp),
    .compare_unsigned(drv.cmpu), .alter_ca(drv.aca), .alter_ov(drv.aov),
    .alter_cr(drv.acr), .output_valid(output_valid), .output_ready(output_ready),
    .rs_id_out(rs_id_out), .result_reg_addr_out(result_reg_addr_out),
    .cr_field_out(cr_field_out), .result(result), .ca(ca), .ov(ov), .cr(cr),
    .ca_valid(ca_valid), .ov_valid(ov_valid), .cr_valid(cr_valid)
  );

  // Small DUT (16 bit, 2 stages)
  op_t  sdrv;
  logic s_input_valid, s_input_ready, s_output_valid;
  logic [4:0] s_rs_id_out, s_result_reg_addr_out;
  logic [2:0] s_cr_field_out;
  logic [15:0] s_result;
  logic s_ca, s_ov, s_ca_valid, s_ov_valid, s_cr_valid;
  logic [3:0] s_cr;

  add_sub_pipe_unit #(.RS_ID_WIDTH(5), .DATA_WIDTH(16), .PIPE_STAGES(SN)) u_small (
    .clk(clk), .rst(rst), .flush(1'b0),
    .input_valid(s_input_valid), .input_ready(s_input_ready),
    .rs_id_in(sdrv.rs_id), .result_reg_addr_in(sdrv.addr), .cr_field_in(sdrv.crf),
    .op1(sdrv.op1[15:0]), .op2(sdrv.op2[15:0]), .carry_in(sdrv.cin), .so_in(sdrv.so),
    .subtract(sdrv.sub), .add_ca(sdrv.add_ca), .compare(sdrv.cmp),
    .compare_unsigned(sdrv.cmpu), .alter_ca(sdrv.aca), .alter_ov(sdrv.aov),
    .alter_cr(sdrv.acr), .output_valid(s_output_valid), .output_ready(1'b1),
    .rs_id_out(s_rs_id_out), .result_reg_addr_out(s_result_reg_addr_out),
    .cr_field_out(s_cr_field_out), .result(s_result), .ca(s_ca), .ov(s_ov), .cr(s_cr),
    .ca_valid(s_ca_valid), .ov_valid(s_ov_valid), .cr_valid(s_cr_valid)
  );

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic longint sx(longint v, int w);
    return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
  endfunction

  function automatic exp_t model(int w, op_t o);
    exp_t   e;
    longint mask, x1, x2, a, s, r, ss, c;
    bit     lt, gt, eq;
    mask    = (longint'(1) << w) - 1;
    x1      = longint'(o.op1) & mask;
    x2      = longint'(o.op2) & mask;
    e       = '0;
    e.rs_id = o.rs_id;
    e.addr  = o.addr;
    e.crf   = o.crf;
    if (o.cmp) begin
      lt    = o.cmpu ? (x1 < x2) : (sx(x1, w) < sx(x2, w));
      eq    = (x1 == x2);
      gt    = !lt && !eq;
      e.cr  = {lt, gt, eq, o.so};
      e.crv = 1'b1;
    end else begin
      a     = o.sub ? (mask - x1) : x1;
      c     = o.add_ca ? longint'(o.cin) : longint'(o.sub);
      s     = a + x2 + c;
      r     = s & mask;
      e.ca  = (s > mask);
      ss    = sx(a, w) + sx(x2, w) + c;
      e.ov  = (ss > ((longint'(1) << (w - 1)) - 1)) || (ss < -(longint'(1) << (w - 1)));
      e.result = r[31:0];
      lt    = sx(r, w) < 0;
      eq    = (r == 0);
      gt    = !lt && !eq;
      e.cr  = {lt, gt, eq, o.so | (o.aov & e.ov)};
      e.cav = o.aca;
      e.ovv = o.aov;
      e.crv = o.acr;
    end
    return e;
  endfunction

  // ca/ov carry no defined value in compare mode, so they are not compared there.
  function automatic bit same(exp_t act, exp_t exp, bit cmp);
    exp_t msk;
    msk = '1;
    if (cmp) begin
      msk.ca = 1'b0;
      msk.ov = 1'b0;
    end
    return ((act ^ exp) & msk) == '0;
  endfunction

  function automatic op_t mk(int rs, logic [31:0] a, logic [31:0] b);
    op_t o;
    o       = '0;
    o.rs_id = rs[4:0];
    o.addr  = 5'(rs + 3);
    o.crf   = 3'(rs);
    o.op1   = a;
    o.op2   = b;
    o.aca   = 1'b1;
    o.aov   = 1'b1;
    o.acr   = 1'b1;
    return o;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o        = mk(int'($urandom_range(0, 31)), rnd_val(), rnd_val());
    o.cin    = 1'($urandom);
    o.so     = ($urandom_range(0, 3) == 0);
    o.sub    = 1'($urandom);
    o.add_ca = 1'($urandom);
    o.cmp    = ($urandom_range(0, 3) == 0);
    o.cmpu   = 1'($urandom);
    o.aca    = 1'($urandom);
    o.aov    = 1'($urandom);
    o.acr    = 1'($urandom);
    return o;
  endfunction

  // Monitor / scoreboard for the main DUT.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (output_valid) ov_seen++;
      if (output_valid && output_ready) begin
        exp_t act;
        sb_t  x;
        act = {rs_id_out, result_reg_addr_out, cr_field_out, result, ca, ov, cr,
               ca_valid, ov_valid, cr_valid};
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output: got %h, expected no output", act);
        end else begin
          x = sb.pop_front();
          if (!same(act, x.e, x.cmp)) begin
            miscompares++;
            $display("FAIL result: got %h expected %h", act, x.e);
          end
          if (x.chk) begin
            vectors++;
            if (cyc - x.acc != N) begin
              miscompares++;
              $display("FAIL latency: got %0d expected %0d", cyc - x.acc, N);
            end
          end
        end
      end
      if (flush) sb.delete();
      if (input_valid && input_ready) sb.push_back('{model(32, drv), cyc, chk_lat, drv.cmp});
    end
  end

  task automatic check(string name, bit ok, longint act, longint exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input op_t o, input int budget, output bit acc);
    drv         = o;
    input_valid = 1'b1;
    acc         = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (input_ready) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    input_valid = 1'b0;
  endtask

  task automatic send_ok(input op_t o);
    bit acc;
    send(o, 20, acc);
    check("accept", acc, acc, 1);
  endtask

  task automatic drain(int budget);
    int i;
    for (i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", sb.size() == 0, sb.size(), 0);
  endtask

  task automatic small_op(input op_t o);
    exp_t e, act;
    int   c0;
    bit   seen;
    sdrv          = o;
    s_input_valid = 1'b1;
    @(negedge clk);
    check("small_ready", s_input_ready, s_input_ready, 1);
    c0 = cyc;
    @(posedge clk); #1;
    s_input_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = s_output_valid;
    end
    check("small_latency", seen && (cyc - c0 == SN), cyc - c0, SN);
    e   = model(16, o);
    act = {s_rs_id_out, s_result_reg_addr_out, s_cr_field_out, 16'h0, s_result, s_ca, s_ov,
           s_cr, s_ca_valid, s_ov_valid, s_cr_valid};
    check("small_result", same(act, e, o.cmp), act, e);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    bit  acc;
    int  seen0;
    rst = 1'b1; flush = 1'b0; input_valid = 1'b0; output_ready = 1'b0;
    s_input_valid = 1'b0; drv = '0; sdrv = '0;
    #12;
    check("reset_outputs", {output_valid, rs_id_out, result_reg_addr_out, cr_field_out,
          result, ca, ov, cr, ca_valid, ov_valid, cr_valid} == '0, output_valid, 0);
    check("reset_small", {s_output_valid, s_result, s_cr} == '0, s_output_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    output_ready = 1'b1;

    // Directed arithmetic and compare, each on an empty pipe.
    chk_lat = 1'b1;
    o = mk(1, 32'd5, 32'd7);                       send_ok(o); drain(20);
    o = mk(2, 32'h7FFF_FFFF, 32'h1);               send_ok(o); drain(20);
    o = mk(3, 32'h1, 32'h0); o.sub = 1; o.add_ca = 1; o.cin = 0;
    send_ok(o); drain(20);
    o.rs_id = 4; o.cin = 1;                        send_ok(o); drain(20);
    o = mk(5, 32'hFFFF_FFFF, 32'h1); o.cmp = 1;    send_ok(o); drain(20);
    o.rs_id = 6; o.cmpu = 1;                       send_ok(o); drain(20);
    chk_lat = 1'b0;

    // Backpressure: four ops fill the pipe, the fifth must stall.
    output_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      o = mk(10 + i, $urandom, $urandom);
      send(o, 3, acc);
      check("bp_accept", acc, acc, 1);
    end
    o = mk(14, $urandom, $urandom);
    send(o, 6, acc);
    check("bp_stall", !acc && !input_ready, acc, 0);
    output_ready = 1'b1;
    send_ok(o);
    o = mk(15, $urandom, $urandom);
    send_ok(o);
    drain(40);

    // Flush with three ops in flight; a new op offered during flush is dropped.
    for (int i = 0; i < 3; i++) begin
      o = mk(20 + i, $urandom, $urandom);
      send_ok(o);
    end
    flush = 1'b1;
    input_valid = 1'b1;
    drv = mk(23, 32'd1, 32'd2);
    @(negedge clk);
    check("flush_ready", !input_ready, input_ready, 0);
    seen0 = ov_seen;
    @(posedge clk); #1;
    flush = 1'b0;
    input_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("flush_no_output", ov_seen == seen0, ov_seen - seen0, 0);
    chk_lat = 1'b1;
    o = mk(24, 32'd100, 32'd200); send_ok(o); drain(20);
    chk_lat = 1'b0;

    // Asynchronous reset with ops buffered behind a stalled consumer.
    output_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      o = mk(25 + i, $urandom | 32'h1, $urandom);
      send_ok(o);
    end
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_valid", output_valid, output_valid, 1);
    rst = 1'b1;
    #1;
    check("async_reset", {output_valid, rs_id_out, result_reg_addr_out, cr_field_out,
          result, ca, ov, cr, ca_valid, ov_valid, cr_valid} == '0, output_valid, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    output_ready = 1'b1;
    seen0 = ov_seen;
    repeat (6) @(posedge clk);
    #1;
    check("reset_no_output", ov_seen == seen0, ov_seen - seen0, 0);

    // Randomised traffic with random backpressure and occasional flush.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      drv          = rnd_op();
      input_valid  = ($urandom_range(0, 3) != 0);
      output_ready = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk); #1;
    input_valid = 1'b0; flush = 1'b0; output_ready = 1'b1;
    drain(40);

    // 16-bit, 2-stage configuration.
    o = mk(1, 32'hFFFF, 32'h1);                    small_op(o);
    o = mk(2, 32'h5, 32'h3); o.sub = 1;            small_op(o);
    o = mk(3, 32'h8000, 32'h1); o.cmp = 1;         small_op(o);
    for (int i = 0; i < 6; i++) small_op(rnd_op());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_sub_pipe_unit.md
Name: add_sub_pipe_unit

Overview:
- Parametrised, width- and depth-configurable integer add/subtract/compare execution unit for the PowerPC reservation-station backend.
- Accepts one operation per cycle from an RS over a valid/ready handshake.
- Computes sum/difference with carry-in, plus CA, OV and a CR field. Supports signed/unsigned compare mode and a pipeline flush.
- Returns results with RS id and destination address after a fixed PIPE_STAGES-cycle latency.

Parameters:
- RS_ID_WIDTH, 5, width of reservation-station tag.
- DATA_WIDTH, 32, operand/result width; legal 8..64.
- PIPE_STAGES, 4, register stages from input to output; legal 2..8.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; invalidates all in-flight ops.
- input_valid  in  1  op presented.
- input_ready  out  1  unit accepts op this cycle.
- rs_id_in  in  RS_ID_WIDTH  RS tag.
- result_reg_addr_in  in  5  destination GPR.
- cr_field_in  in  3  destination CR field (CR0 for record forms).
- op1, op2  in  DATA_WIDTH  operands (rA, rB).
- carry_in  in  1  XER[CA].
- so_in  in  1  XER[SO].
- subtract, add_ca  in  1  control.
- compare, compare_unsigned  in  1  control.
- alter_ca, alter_ov, alter_cr  in  1  control.
- output_valid  out  1  result presented.
- output_ready  in  1  consumer accepts.
- rs_id_out  out  RS_ID_WIDTH  tag.
- result_reg_addr_out  out  5  destination.
- cr_field_out  out  3  destination CR field.
- result  out  DATA_WIDTH  sum/difference; 0 in compare mode.
- ca, ov  out  1  XER flags.
- cr  out  4  {LT, GT, EQ, SO}.
- ca_valid, ov_valid, cr_valid  out  1  writeback enables.

Behaviour:
- Reset: all stage valids 0; every output, including output_valid, is 0. Reset asserted mid-operation discards all in-flight ops.
- Stage enables, N = PIPE_STAGES:
  - en[N-1] = output_ready | ~valid[N-1].
  - en[k] = ~valid[k] | en[k+1].
  - input_ready = en[0] (combinational; bubbles collapse).
  - An enabled stage loads its upstream valid and payload; a disabled stage holds.
- Latency: with output_ready held 1, an op accepted at edge t appears at output after edge t+N-1, i.e. N cycles. Throughput is 1 op/cycle.
- Backpressure: with output_ready=0, at most N ops are buffered, then input_ready=0. No op is dropped or duplicated.
- Arithmetic mode (compare=0):
  - a = subtract ? ~op1 : op1.
  - cin = add_ca ? carry_in : subtract.
  - {ca, result} = a + op2 + cin, evaluated in DATA_WIDTH+1 bits (subtract yields op2-op1).
  - ov = carry into MSB XOR carry out.
  - LT = result[MSB].
  - GT = ~LT & (result != 0).
  - EQ = (result == 0).
  - SO = so_in | (alter_ov & ov).
  - ca_valid = alter_ca; ov_valid = alter_ov; cr_valid = alter_cr.
- Compare mode (compare=1):
  - LT/GT/EQ from op1 vs op2, signed unless compare_unsigned.
  - SO = so_in; result = 0; ca_valid = ov_valid = 0; cr_valid = 1.
  - subtract, add_ca and alter_* are ignored.
- The carry chain is split across at least two register stages. Internal partitioning is otherwise free, provided the latency is exactly N.
- Flush:
  - At the next edge all valid[k] clear; payload is don't-care; output_valid is 0 the following cycle.
  - input_ready is forced 0 while flush=1; input on that cycle is dropped.
  - Flush has priority over a simultaneous output handshake: the consumer sees the handshake only if output_valid & output_ready were both 1 before the edge (that transfer completes).
- Outputs are registered; output payload is stable while output_valid=1 and output_ready=0.

Test Plan:
- Default params, output_ready=1: op1=5, op2=7, add → after 4 cycles result=12, ca=0, ov=0, cr=0100 with alter_cr=1.
- Overflow: op1=0x7FFFFFFF, op2=1, add, alter_ov → result=0x80000000, ov=1, cr=1001 with so_in=0.
- Subtract with carry: subtract+add_ca, op1=1, op2=0, carry_in=0 → result=0xFFFFFFFE, ca=0. Same with carry_in=1 → result=0xFFFFFFFF, ca=0.
- Compare: op1=0xFFFFFFFF, op2=1. Signed → cr=1000; unsigned → cr=0100; both with result=0, cr_valid=1, ca_valid=0.
- Backpressure: stream 6 ops with output_ready=0 → input_ready drops after 4 accepts. Then raise output_ready → all 6 emerge in order with matching rs_id, none lost.
- Flush/reset: 3 ops in flight, pulse flush → no output_valid thereafter, next op has normal 4-cycle latency. Async rst mid-stream → all outputs 0 immediately. Repeat with DATA_WIDTH=16, PIPE_STAGES=2: 0xFFFF+1 → result=0, ca=1, latency 2.
